// File: rtl/uart_pkg.sv
// Shared types and constants for the UART byte receiver.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_pkg;

  // Payload width is tied to the 8-bit character path downstream.
  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_t;

  // Width of a counter that must hold 0..clks_per_bit-1.
  function automatic int CNT_W(input int clks_per_bit);
    return (clks_per_bit < 2) ? 1 : $clog2(clks_per_bit);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for one asynchronous bit, reset to a chosen level.
// Latency: 2 clk from d to q.
// Backpressure: none; samples every cycle.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; reset both to the idle level so no false edge appears.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_byte.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined): mid-bit sampling, glitch/framing checks.
// Latency: start edge to data_valid = 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT (+CLKS_PER_BIT with parity) + 1 clk.
// Backpressure: none; data_valid/frame_err/parity_err are one-cycle strobes the consumer must take.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam int CW = CNT_W(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  logic                 rx_s;
  state_t               state, state_nxt;
  logic [CW-1:0]        clk_cnt, cnt_nxt;
  logic [IW-1:0]        bit_idx, idx_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic [7:0]           dout_nxt;
  logic                 valid_nxt;
  logic                 ferr_nxt;
  logic                 bit_end;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad, par_bad_nxt;
  logic                 perr_nxt;
`endif

  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_rx_sync (
    .clk(clk),
    .rst(rst),
    .d  (rx),
    .q  (rx_s)
  );

  assign bit_end = (clk_cnt == CNT_LAST);

  // Next-state, counters, shift register and strobe decode.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = clk_cnt + 1'b1;
    idx_nxt   = bit_idx;
    shift_nxt = shift;
    dout_nxt  = data_out;
    valid_nxt = 1'b0;
    ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_nxt = par_bad;
    perr_nxt    = 1'b0;
`endif
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        idx_nxt = '0;
`ifdef UART_RX_PARITY_EN
        par_bad_nxt = 1'b0;
`endif
        if (!rx_s) state_nxt = START;
      end
      START: begin
        // Re-check the line half a bit in; a high level means the edge was noise.
        if (clk_cnt == CNT_HALF) begin
          cnt_nxt   = '0;
          state_nxt = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_nxt            = '0;
          shift_nxt[bit_idx] = rx_s;
          idx_nxt            = bit_idx + 1'b1;
          if (bit_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        // Even parity: data ones plus parity bit must be even.
        if (bit_end) begin
          cnt_nxt     = '0;
          par_bad_nxt = rx_s ^ (^shift);
          state_nxt   = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          cnt_nxt = '0;
          if (rx_s) begin
            state_nxt = IDLE;
`ifdef UART_RX_PARITY_EN
            if (par_bad) begin
              perr_nxt = 1'b1;
            end else begin
              valid_nxt = 1'b1;
              dout_nxt  = shift;
            end
`else
            valid_nxt = 1'b1;
            dout_nxt  = shift;
`endif
          end else begin
            ferr_nxt  = 1'b1;
            state_nxt = BREAK;
          end
        end
      end
      BREAK: begin
        // Hold off until the line returns high so a stuck-low line spawns no frames.
        cnt_nxt = '0;
        if (rx_s) state_nxt = IDLE;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // State, datapath and registered output strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      clk_cnt    <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      clk_cnt    <= cnt_nxt;
      bit_idx    <= idx_nxt;
      shift      <= shift_nxt;
      data_out   <= dout_nxt;
      data_valid <= valid_nxt;
      frame_err  <= ferr_nxt;
`ifdef UART_RX_PARITY_EN
      par_bad    <= par_bad_nxt;
      parity_err <= perr_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Bench for uart_rx_byte: bit-accurate line driver, event monitor, frame-level reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_rx_byte;

  localparam int CPB = 8;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
  localparam bit PAR_EN = 1'b1;
`else
  localparam int NBITS = 10;
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int LAT = 2 + CPB / 2 + 9 * CPB + (PAR_EN ? CPB : 0) + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int both_cnt = 0;
  int last_start = 0;
  logic [7:0] last_good;

  // kind: 0 = data_valid, 1 = frame_err, 2 = parity_err
  typedef struct {
    int         kind;
    logic [7:0] b;
    int         t;
  } ev_t;

  ev_t got_q[$];
  ev_t exp_q[$];

  uart_rx_byte #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data_out  (data_out),
    .data_valid(data_valid),
    .frame_err (frame_err)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic ev_t mk_ev(input int kind, input logic [7:0] b, input int t);
    ev_t e;
    e.kind = kind;
    e.b    = b;
    e.t    = t;
    return e;
  endfunction

  // Downstream combinational toUpper stage.
  function automatic logic [7:0] to_upper(input logic [7:0] c);
    return (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
  endfunction

  // Record every strobe as it appears on the outputs.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (data_valid) got_q.push_back(mk_ev(0, data_out, cyc));
      if (frame_err) got_q.push_back(mk_ev(1, data_out, cyc));
`ifdef UART_RX_PARITY_EN
      if (parity_err) got_q.push_back(mk_ev(2, data_out, cyc));
`endif
      if (data_valid && frame_err) both_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    tick(CPB);
  endtask

  // Drives start, 8 data bits LSB first, optional even parity, stop; line left at the stop level.
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic par_ok);
    last_start = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    if (PAR_EN) drive_bit((^b) ^ ~par_ok);
    drive_bit(stop_v);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    rx  = 1'b1;
    tick(3);
    @(negedge clk);
    checks++;
    if (data_out !== 8'h00) begin failures++; $display("FAIL reset_data_out got=%h exp=00", data_out); end
    checks++;
    if (data_valid !== 1'b0) begin failures++; $display("FAIL reset_data_valid got=%b exp=0", data_valid); end
    checks++;
    if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
`ifdef UART_RX_PARITY_EN
    checks++;
    if (parity_err !== 1'b0) begin failures++; $display("FAIL reset_parity_err got=%b exp=0", parity_err); end
`endif
    tick(1);
    rst = 1'b0;
    tick(3 * CPB);
    checks++;
    if (got_q.size() != 0) begin failures++; $display("FAIL idle_no_strobe got=%0d exp=0", got_q.size()); end
  endtask

  task automatic test_single;
    int lat;
    got_q.delete();
    send_frame(8'h61, 1'b1, 1'b1);
    tick(4);
    checks++;
    if (got_q.size() != 1) begin failures++; $display("FAIL single_count got=%0d exp=1", got_q.size()); end
    if (got_q.size() >= 1) begin
      checks++;
      if (got_q[0].kind != 0 || got_q[0].b !== 8'h61) begin
        failures++; $display("FAIL single_byte got kind=%0d b=%h exp kind=0 b=61", got_q[0].kind, got_q[0].b);
      end
      checks++;
      if (to_upper(got_q[0].b) !== 8'h41) begin
        failures++; $display("FAIL single_toupper got=%h exp=41", to_upper(got_q[0].b));
      end
      lat = got_q[0].t - last_start;
      checks++;
      if (lat < LAT - 1 || lat > LAT + 1) begin
        failures++; $display("FAIL single_latency got=%0d exp=%0d+/-1", lat, LAT);
      end
    end
    @(negedge clk);
    checks++;
    if (data_out !== 8'h61 || frame_err !== 1'b0) begin
      failures++; $display("FAIL single_hold got data=%h ferr=%b exp data=61 ferr=0", data_out, frame_err);
    end
    tick(1);
    last_good = 8'h61;
  endtask

  task automatic test_back_to_back;
    logic [7:0] bytes [3];
    bytes[0] = 8'h48;
    bytes[1] = 8'h7A;
    bytes[2] = 8'hEB;
    got_q.delete();
    for (int i = 0; i < 3; i++) send_frame(bytes[i], 1'b1, 1'b1);
    tick(4);
    checks++;
    if (got_q.size() != 3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", got_q.size()); end
    for (int i = 0; i < 3; i++) begin
      if (got_q.size() > i) begin
        checks++;
        if (got_q[i].kind != 0 || got_q[i].b !== bytes[i]) begin
          failures++; $display("FAIL b2b_byte%0d got kind=%0d b=%h exp kind=0 b=%h", i, got_q[i].kind, got_q[i].b, bytes[i]);
        end
        if (i > 0) begin
          checks++;
          if (got_q[i].t - got_q[i-1].t != NBITS * CPB) begin
            failures++; $display("FAIL b2b_spacing%0d got=%0d exp=%0d", i, got_q[i].t - got_q[i-1].t, NBITS * CPB);
          end
        end
      end
    end
    last_good = 8'hEB;
  endtask

  task automatic test_glitch;
    got_q.delete();
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(3 * CPB);
    checks++;
    if (got_q.size() != 0) begin failures++; $display("FAIL glitch_no_strobe got=%0d exp=0", got_q.size()); end
    send_frame(8'h28, 1'b1, 1'b1);
    tick(4);
    checks++;
    if (got_q.size() != 1 || got_q[0].kind != 0 || got_q[0].b !== 8'h28) begin
      failures++; $display("FAIL glitch_recover got count=%0d exp count=1 b=28", got_q.size());
    end
    last_good = 8'h28;
  endtask

  task automatic test_frame_err;
    got_q.delete();
    both_cnt = 0;
    send_frame(8'h7C, 1'b0, 1'b1);
    tick(40);
    checks++;
    if (got_q.size() != 1) begin failures++; $display("FAIL ferr_count got=%0d exp=1", got_q.size()); end
    if (got_q.size() >= 1) begin
      checks++;
      if (got_q[0].kind != 1 || got_q[0].b !== last_good) begin
        failures++; $display("FAIL ferr_event got kind=%0d data=%h exp kind=1 data=%h", got_q[0].kind, got_q[0].b, last_good);
      end
    end
    checks++;
    if (both_cnt != 0) begin failures++; $display("FAIL ferr_exclusive got=%0d exp=0", both_cnt); end
    rx = 1'b1;
    tick(2 * CPB);
    checks++;
    if (got_q.size() != 1) begin failures++; $display("FAIL ferr_break_quiet got=%0d exp=1", got_q.size()); end
    send_frame(8'h3E, 1'b1, 1'b1);
    tick(4);
    checks++;
    if (got_q.size() != 2 || got_q[got_q.size()-1].kind != 0 || got_q[got_q.size()-1].b !== 8'h3E) begin
      failures++; $display("FAIL ferr_recover got count=%0d exp count=2 last=3e", got_q.size());
    end
    last_good = 8'h3E;
  endtask

  task automatic test_reset_mid;
    logic [7:0] b;
    b = 8'h6D;
    got_q.delete();
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    rx = b[4];
    tick(CPB / 2);
    rst = 1'b1;
    tick(1);
    @(negedge clk);
    checks++;
    if (data_out !== 8'h00 || data_valid !== 1'b0 || frame_err !== 1'b0) begin
      failures++; $display("FAIL midreset_outputs got data=%h v=%b fe=%b exp 00/0/0", data_out, data_valid, frame_err);
    end
    tick(1);
    rst = 1'b0;
    rx  = 1'b1;
    tick(3 * CPB);
    checks++;
    if (got_q.size() != 0) begin failures++; $display("FAIL midreset_no_strobe got=%0d exp=0", got_q.size()); end
    send_frame(8'h30, 1'b1, 1'b1);
    tick(4);
    checks++;
    if (got_q.size() != 1 || got_q[0].kind != 0 || got_q[0].b !== 8'h30) begin
      failures++; $display("FAIL midreset_recover got count=%0d exp count=1 b=30", got_q.size());
    end
    last_good = 8'h30;
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    got_q.delete();
    send_frame(8'h47, 1'b1, 1'b0);
    tick(4);
    checks++;
    if (got_q.size() != 1 || got_q[0].kind != 2 || got_q[0].b !== last_good) begin
      failures++; $display("FAIL parity_bad got count=%0d exp count=1 kind=2 data=%h", got_q.size(), last_good);
    end
    got_q.delete();
    send_frame(8'h47, 1'b1, 1'b1);
    tick(4);
    checks++;
    if (got_q.size() != 1 || got_q[0].kind != 0 || got_q[0].b !== 8'h47) begin
      failures++; $display("FAIL parity_good got count=%0d exp count=1 kind=0 b=47", got_q.size());
    end
    last_good = 8'h47;
  endtask
`endif

  task automatic test_random;
    logic [7:0] b;
    logic       bad_stop;
    logic       bad_par;
    logic [7:0] model_last;
    got_q.delete();
    exp_q.delete();
    both_cnt = 0;
    model_last = last_good;
    for (int n = 0; n < 24; n++) begin
      b        = 8'($urandom);
      bad_stop = ($urandom_range(0, 4) == 0);
      bad_par  = PAR_EN && ($urandom_range(0, 4) == 0);
      send_frame(b, ~bad_stop, ~bad_par);
      if (bad_stop) begin
        exp_q.push_back(mk_ev(1, model_last, 0));
        tick($urandom_range(0, 16));
        rx = 1'b1;
        tick(CPB + $urandom_range(0, 8));
      end else if (bad_par) begin
        exp_q.push_back(mk_ev(2, model_last, 0));
      end else begin
        exp_q.push_back(mk_ev(0, b, 0));
        model_last = b;
      end
      tick($urandom_range(0, 12));
    end
    tick(4);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++; $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (got_q.size() > i) begin
        checks++;
        if (got_q[i].kind != exp_q[i].kind || got_q[i].b !== exp_q[i].b) begin
          failures++;
          $display("FAIL rand_ev%0d got kind=%0d data=%h exp kind=%0d data=%h", i, got_q[i].kind, got_q[i].b, exp_q[i].kind, exp_q[i].b);
        end
      end
    end
    checks++;
    if (both_cnt != 0) begin failures++; $display("FAIL rand_exclusive got=%0d exp=0", both_cnt); end
    last_good = model_last;
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    last_good = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute bound on run time.
  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

endmodule
